vmv_issue_ctrl: RTL and testbench
=================================

VMV_ISSUE_CTRL -- requirements
Module: vmv_issue_ctrl

Interface
REQ-001 Parameter DATA_W, default 64, beat data width; equals the move datapath width.
REQ-002 Parameter PIPE_LAT, default 4, fixed move-datapath latency in cycles from dp_in_valid to dp_out_valid.
REQ-003 Parameter FIFO_DEPTH, default 8, response buffer entries; power of two, at least 2.
REQ-004 clk  in  1  clock; all logic rising-edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 rqN_valid / rqN_ready / rqN_data[DATA_W] / rqN_last, N=0,1  in/out/in/in  requester N beat stream.
REQ-007 dp_in_valid / dp_in_vec[DATA_W]  out  issue to move datapath.
REQ-008 dp_out_valid / dp_out_vec[DATA_W]  in  datapath result.
REQ-009 rsp_valid / rsp_ready / rsp_data[DATA_W] / rsp_id / rsp_last  out/in/out/out/out  response stream.
REQ-010 err_sticky  out  1  set on protocol violation.

Function
REQ-011 FSM states: IDLE, BURST0, BURST1; exactly one requester owns the datapath per burst.
REQ-012 IDLE: grant to a requester with rqN_valid per arbitration (REQ-026/027); transition to BURSTN that cycle; first beat accepted no earlier than the next cycle.
REQ-013 BURSTN: rqN_ready = credit>0; the other requester's ready is 0.
REQ-014 Beat accepted when rqN_valid & rqN_ready; that cycle dp_in_valid=1, dp_in_vec=rqN_data; otherwise dp_in_valid=0, dp_in_vec=0.
REQ-015 An accepted beat with rqN_last=1 returns the FSM to IDLE the next cycle; bursts of one beat are legal.
REQ-016 Tag shift register of PIPE_LAT stages carries {valid,id,last} alongside each issued beat.
REQ-017 When tag stage PIPE_LAT-1 is valid, dp_out_vec with its id/last is pushed into the response FIFO.
REQ-018 dp_out_valid disagreeing with the tag valid bit sets err_sticky; the push is governed by the tag valid bit only.
REQ-019 Credit counter, range 0..FIFO_DEPTH: decrements on issue, increments on FIFO pop, unchanged when both occur in the same cycle.
REQ-020 Credit guarantees no FIFO overflow; push to a full FIFO sets err_sticky and drops the beat.
REQ-021 rsp_valid = FIFO not empty; pop on rsp_valid & rsp_ready; simultaneous push and pop at full or empty is legal.
REQ-022 Ordering: responses leave in issue order; issue-to-rsp_valid minimum latency is PIPE_LAT+1 cycles.

Reset
REQ-023 On rst: FSM in IDLE, both readies 0, dp_in_valid 0, dp_in_vec 0, tags cleared, FIFO empty, rsp outputs 0, credit=FIFO_DEPTH, arbitration pointer=0, err_sticky 0.
REQ-024 Reset mid-burst discards in-flight and buffered beats; dp_out_valid pulses within PIPE_LAT cycles after reset are ignored and do not set err_sticky.
REQ-025 Reset dominates all simultaneous events.

Configuration
REQ-026 With VMV_ARB_RR_EN defined: round-robin; the pointer moves to the non-granted requester when a burst ends; on a tie the pointer's requester wins.
REQ-027 Without VMV_ARB_RR_EN: fixed priority, requester 0 always wins ties; the pointer is absent.

Structure
REQ-028 Shared package vmv_pkg holds the FSM state enum, the tag struct {valid,id,last}, and the default PIPE_LAT/FIFO_DEPTH constants.
REQ-029 One sub-module, vmv_rsp_fifo: synchronous FIFO storing {data,id,last}, with full/empty outputs.

Verification
REQ-030 rq0 sends a 3-beat burst (0x11,0x22,0x33), rsp_ready=1 -> rsp beats 0x11,0x22,0x33, id=0, last only on 0x33, first rsp_valid 5 cycles after the first issue.
REQ-031 Both valid in IDLE with RR_EN, one-beat bursts -> grants alternate 0,1,0,1; without RR_EN -> four consecutive grants to 0.
REQ-032 rsp_ready=0, rq1 streams 12 beats -> exactly 8 issued, rq1_ready 0 after that; raising rsp_ready drains and resumes issue, with all 12 beats returned in order.
REQ-033 rst asserted 2 cycles into a burst -> FIFO empty, credit 8, err_sticky stays 0, no rsp_valid afterwards.
REQ-034 Inject dp_out_valid=1 with no issued beat -> err_sticky=1 next cycle and no FIFO push.
REQ-035 FIFO full, then simultaneous pop and datapath arrival -> occupancy stays 8, credit unchanged.

Source files
------------

// File: rtl/vmv_pkg.sv
// Shared types and defaults for the vector-move issue controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vmv_pkg;

    localparam int VMV_PIPE_LAT_DEF   = 4;
    localparam int VMV_FIFO_DEPTH_DEF = 8;

    // Issue FSM: idle, or one requester owns the datapath for a whole burst.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BURST0 = 2'd1,
        ST_BURST1 = 2'd2
    } vmv_state_t;

    // Side-band tag that travels next to each beat in the move datapath.
    typedef struct packed {
        logic valid;
        logic id;
        logic last;
    } vmv_tag_t;

endpackage

// File: rtl/vmv_rsp_fifo.sv
// Synchronous response FIFO holding {data, id, last}; full/empty flags.
// Latency: push visible on the read side the cycle after the push edge.
// Backpressure: push at full is dropped unless a pop happens in the same cycle.
//
// Ports: clk/rst (sync, active-high); push/push_data/push_id/push_last write side;
//        pop/pop_data/pop_id/pop_last read side (outputs zero when empty); full, empty.
module vmv_rsp_fifo
    import vmv_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = VMV_FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_id,
    input  logic              push_last,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_id,
    output logic              pop_last,
    output logic              full,
    output logic              empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              id;
        logic              last;
    } entry_t;

    entry_t            mem [DEPTH];
    entry_t            head;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so push at full is still legal then.
    assign do_push = push && (!full || do_pop);

    assign head     = mem[rd_ptr];
    assign pop_data = empty ? '0 : head.data;
    assign pop_id   = empty ? 1'b0 : head.id;
    assign pop_last = empty ? 1'b0 : head.last;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= '{data: push_data, id: push_id, last: push_last};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vmv_issue_ctrl.sv
// Arbitrates two beat streams onto a fixed-latency move datapath and buffers results.
// Latency: issue to rsp_valid is PIPE_LAT+1 cycles minimum; grant takes one idle cycle.
// Backpressure: credit-based; requester ready drops when datapath + FIFO hold FIFO_DEPTH beats.
//
// Ports: clk, rst (sync, active-high); rq0_*/rq1_* requester valid/ready/data/last;
//        dp_in_valid/dp_in_vec issue to datapath; dp_out_valid/dp_out_vec datapath result;
//        rsp_valid/rsp_ready/rsp_data/rsp_id/rsp_last response stream; err_sticky protocol error.
// Build option: define VMV_ARB_RR_EN for round-robin arbitration (default: fixed priority, rq0 first).
module vmv_issue_ctrl
    import vmv_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int PIPE_LAT   = VMV_PIPE_LAT_DEF,
    parameter int FIFO_DEPTH = VMV_FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rq0_valid,
    output logic              rq0_ready,
    input  logic [DATA_W-1:0] rq0_data,
    input  logic              rq0_last,
    input  logic              rq1_valid,
    output logic              rq1_ready,
    input  logic [DATA_W-1:0] rq1_data,
    input  logic              rq1_last,
    output logic              dp_in_valid,
    output logic [DATA_W-1:0] dp_in_vec,
    input  logic              dp_out_valid,
    input  logic [DATA_W-1:0] dp_out_vec,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_id,
    output logic              rsp_last,
    output logic              err_sticky
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = $clog2(PIPE_LAT + 1);

    vmv_state_t                 state;
    vmv_tag_t [PIPE_LAT-1:0]    tag_q;
    vmv_tag_t                   tag_out;
    vmv_tag_t                   issue_tag;
    logic [CW-1:0]              credit;
    logic [IW-1:0]              ign_cnt;
    logic                       acc0;
    logic                       acc1;
    logic                       issue;
    logic                       gnt1;
    logic                       pop;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [DATA_W-1:0]          fifo_data;
    logic                       fifo_id;
    logic                       fifo_last;
    logic                       overflow;
    logic                       mismatch;
`ifdef VMV_ARB_RR_EN
    logic                       rr_ptr;
`endif

    // Readies are gated by rst so nothing is accepted in a reset cycle.
    assign rq0_ready = !rst && (state == ST_BURST0) && (credit != '0);
    assign rq1_ready = !rst && (state == ST_BURST1) && (credit != '0);

    assign acc0  = rq0_valid && rq0_ready;
    assign acc1  = rq1_valid && rq1_ready;
    assign issue = acc0 || acc1;

    assign dp_in_valid = issue;
    assign dp_in_vec   = acc0 ? rq0_data : (acc1 ? rq1_data : '0);

    assign issue_tag = '{valid: issue, id: acc1, last: acc0 ? rq0_last : (acc1 && rq1_last)};
    assign tag_out   = tag_q[PIPE_LAT-1];

`ifdef VMV_ARB_RR_EN
    assign gnt1 = rq1_valid && (!rq0_valid || rr_ptr);
`else
    assign gnt1 = rq1_valid && !rq0_valid;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
`ifdef VMV_ARB_RR_EN
            rr_ptr <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rq0_valid || rq1_valid) begin
                        state <= gnt1 ? ST_BURST1 : ST_BURST0;
                    end
                end
                ST_BURST0: begin
                    if (acc0 && rq0_last) begin
                        state  <= ST_IDLE;
`ifdef VMV_ARB_RR_EN
                        rr_ptr <= 1'b1;
`endif
                    end
                end
                ST_BURST1: begin
                    if (acc1 && rq1_last) begin
                        state  <= ST_IDLE;
`ifdef VMV_ARB_RR_EN
                        rr_ptr <= 1'b0;
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Tag pipe mirrors the datapath so each result finds its id/last.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q <= '0;
        end else begin
            tag_q[0] <= issue_tag;
            for (int i = 1; i < PIPE_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // Credit covers beats in flight plus beats buffered, so a tagged arrival always fits.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit <= CW'(FIFO_DEPTH);
        end else begin
            case ({issue, pop})
                2'b10:   credit <= credit - 1'b1;
                2'b01:   credit <= credit + 1'b1;
                default: credit <= credit;
            endcase
        end
    end

    // Beats issued before reset still drain out of the datapath for up to
    // PIPE_LAT cycles; their dp_out_valid pulses are not protocol errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            ign_cnt <= IW'(PIPE_LAT);
        end else if (ign_cnt != '0) begin
            ign_cnt <= ign_cnt - 1'b1;
        end
    end

    assign overflow = tag_out.valid && fifo_full && !pop;
    assign mismatch = (dp_out_valid != tag_out.valid) && (ign_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky <= 1'b0;
        end else if (overflow || mismatch) begin
            err_sticky <= 1'b1;
        end
    end

    vmv_rsp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tag_out.valid),
        .push_data (dp_out_vec),
        .push_id   (tag_out.id),
        .push_last (tag_out.last),
        .pop       (pop),
        .pop_data  (fifo_data),
        .pop_id    (fifo_id),
        .pop_last  (fifo_last),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rsp_valid = !fifo_empty && !rst;
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_data  = rsp_valid ? fifo_data : '0;
    assign rsp_id    = rsp_valid && fifo_id;
    assign rsp_last  = rsp_valid && fifo_last;

endmodule

// File: tb/tb_vmv_issue_ctrl.sv
// Directed bench for vmv_issue_ctrl with a fixed-latency datapath model and response scoreboard.
// Latency: datapath model returns each issued beat PIPE_LAT cycles later.
// Backpressure: rsp_ready driven per test to exercise credit stalls.
`timescale 1ns/1ps
module tb_vmv_issue_ctrl;

    localparam int DATA_W     = 64;
    localparam int PIPE_LAT   = 4;
    localparam int FIFO_DEPTH = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rq0_valid = 1'b0;
    logic              rq0_ready;
    logic [DATA_W-1:0] rq0_data = '0;
    logic              rq0_last = 1'b0;
    logic              rq1_valid = 1'b0;
    logic              rq1_ready;
    logic [DATA_W-1:0] rq1_data = '0;
    logic              rq1_last = 1'b0;
    logic              dp_in_valid;
    logic [DATA_W-1:0] dp_in_vec;
    logic              dp_out_valid;
    logic [DATA_W-1:0] dp_out_vec;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_id;
    logic              rsp_last;
    logic              err_sticky;
    logic              inj_valid = 1'b0;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              id;
        logic              last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_issued = 0;
    int   cyc = 0;
    int   base;
    logic drv_done;
    logic saw_rsp;
    logic saw_err;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vmv_issue_ctrl #(
        .DATA_W     (DATA_W),
        .PIPE_LAT   (PIPE_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rq0_valid    (rq0_valid),
        .rq0_ready    (rq0_ready),
        .rq0_data     (rq0_data),
        .rq0_last     (rq0_last),
        .rq1_valid    (rq1_valid),
        .rq1_ready    (rq1_ready),
        .rq1_data     (rq1_data),
        .rq1_last     (rq1_last),
        .dp_in_valid  (dp_in_valid),
        .dp_in_vec    (dp_in_vec),
        .dp_out_valid (dp_out_valid),
        .dp_out_vec   (dp_out_vec),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_id       (rsp_id),
        .rsp_last     (rsp_last),
        .err_sticky   (err_sticky)
    );

    // Fixed-latency move datapath; it is not reset, like the real one.
    logic [PIPE_LAT-1:0] dp_v;
    logic [DATA_W-1:0]   dp_d [PIPE_LAT];
    always @(posedge clk) begin
        dp_v    <= {dp_v[PIPE_LAT-2:0], dp_in_valid};
        dp_d[0] <= dp_in_vec;
        for (int i = 1; i < PIPE_LAT; i++) dp_d[i] <= dp_d[i-1];
    end
    assign dp_out_valid = dp_v[PIPE_LAT-1] | inj_valid;
    assign dp_out_vec   = dp_d[PIPE_LAT-1];

    task automatic check(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic push_exp(input logic [DATA_W-1:0] d, input logic id, input logic last);
        exp_t e;
        e.data = d;
        e.id   = id;
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
    endtask

    // Present one beat on requester n and hold it until the handshake edge.
    task automatic send_beat(input int n, input logic [DATA_W-1:0] d, input logic last);
        int t = 0;
        if (n == 0) begin rq0_valid = 1'b1; rq0_data = d; rq0_last = last; end
        else        begin rq1_valid = 1'b1; rq1_data = d; rq1_last = last; end
        @(negedge clk);
        while (!((n == 0) ? rq0_ready : rq1_ready)) begin
            t++;
            if (t > 500) begin
                n_tests++;
                n_fail++;
                $display("FAIL handshake_timeout rq%0d: beat %0h never accepted", n, d);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        if (n == 0) rq0_valid = 1'b0;
        else        rq1_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(posedge clk);
            t++;
        end
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d responses missing, expected 0 outstanding", exp_q.size());
        end
    endtask

    task automatic wait_done();
        int t = 0;
        while (!drv_done && t < 1000) begin
            @(posedge clk);
            t++;
        end
        #1;
        n_tests++;
        if (!drv_done) begin
            n_fail++;
            $display("FAIL driver_done: stream incomplete, expected all beats accepted");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (!rst && dp_in_valid) n_issued++;
            end
            forever begin
                @(negedge clk);
                if (!rst && rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL rsp_unexpected: got data %0h id %0d, expected no response", rsp_data, rsp_id);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("rsp_data", rsp_data, mon_e.data);
                        check("rsp_id", {63'd0, rsp_id}, {63'd0, mon_e.id});
                        check("rsp_last", {63'd0, rsp_last}, {63'd0, mon_e.last});
                    end
                end
            end
        join_none

        // Reset state, sampled while rst is still asserted.
        tick(3);
        @(negedge clk);
        check("rst_rq0_ready", {63'd0, rq0_ready}, 0);
        check("rst_rq1_ready", {63'd0, rq1_ready}, 0);
        check("rst_dp_in_valid", {63'd0, dp_in_valid}, 0);
        check("rst_dp_in_vec", dp_in_vec, 0);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_err", {63'd0, err_sticky}, 0);
        tick(2);
        rst = 1'b0;

        // Arbitration with one-beat bursts on both requesters.
        rsp_ready = 1'b1;
`ifdef VMV_ARB_RR_EN
        for (int i = 0; i < 4; i++) begin
            push_exp(64'hA0 + i, 1'b0, 1'b1);
            push_exp(64'hB0 + i, 1'b1, 1'b1);
        end
`else
        for (int i = 0; i < 4; i++) push_exp(64'hA0 + i, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) push_exp(64'hB0 + i, 1'b1, 1'b1);
`endif
        fork
            begin for (int i = 0; i < 4; i++) send_beat(0, 64'hA0 + i, 1'b1); end
            begin for (int i = 0; i < 4; i++) send_beat(1, 64'hB0 + i, 1'b1); end
        join
        wait_drain();

        // Three-beat burst from rq0 and issue-to-response latency.
        push_exp(64'h11, 1'b0, 1'b0);
        push_exp(64'h22, 1'b0, 1'b0);
        push_exp(64'h33, 1'b0, 1'b1);
        fork
            begin
                send_beat(0, 64'h11, 1'b0);
                send_beat(0, 64'h22, 1'b0);
                send_beat(0, 64'h33, 1'b1);
            end
            begin
                int k;
                int t0;
                int t1;
                k = 0;
                @(negedge clk);
                check("idle_ready_low", {63'd0, rq0_ready}, 0);
                check("idle_no_issue", {63'd0, dp_in_valid}, 0);
                while (!dp_in_valid && k < 50) begin @(negedge clk); k++; end
                t0 = cyc;
                check("first_issue_vec", dp_in_vec, 64'h11);
                k = 0;
                while (!rsp_valid && k < 50) begin @(negedge clk); k++; end
                t1 = cyc;
                check("issue_to_rsp_latency", t1 - t0, PIPE_LAT + 1);
            end
        join
        wait_drain();

        // Credit stall: 12 beats from rq1 with responses blocked.
        rsp_ready = 1'b0;
        base = n_issued;
        drv_done = 1'b0;
        for (int i = 0; i < 12; i++) push_exp(64'h100 + i, 1'b1, i == 11);
        fork
            begin
                for (int i = 0; i < 12; i++) send_beat(1, 64'h100 + i, i == 11);
                drv_done = 1'b1;
            end
        join_none
        tick(30);
        @(negedge clk);
        check("stall_issued", n_issued - base, 8);
        check("stall_rq1_ready", {63'd0, rq1_ready}, 0);
        check("stall_rsp_valid", {63'd0, rsp_valid}, 1);
        // Single pop from a full FIFO returns exactly one credit.
        @(posedge clk); #1; rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
        @(negedge clk);
        check("credit_return_ready", {63'd0, rq1_ready}, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("credit_consumed_ready", {63'd0, rq1_ready}, 0);
        tick(10);
        @(negedge clk);
        check("refill_issued", n_issued - base, 9);
        check("refill_full_ready", {63'd0, rq1_ready}, 0);
        @(posedge clk); #1; rsp_ready = 1'b1;
        wait_done();
        wait_drain();
        check("stream_issued", n_issued - base, 12);

        // Datapath result with no issued beat behind it.
        rsp_ready = 1'b0;
        tick(10);
        @(negedge clk);
        check("err_before_inject", {63'd0, err_sticky}, 0);
        @(posedge clk); #1; inj_valid = 1'b1;
        @(posedge clk); #1; inj_valid = 1'b0;
        @(negedge clk);
        check("err_after_inject", {63'd0, err_sticky}, 1);
        tick(8);
        @(negedge clk);
        check("inject_no_push", {63'd0, rsp_valid}, 0);
        check("err_sticky_holds", {63'd0, err_sticky}, 1);

        // Reset two beats into a burst, with results still in the datapath.
        do_reset();
        @(negedge clk);
        check("reset_clears_err", {63'd0, err_sticky}, 0);
        @(posedge clk); #1;
        rq0_valid = 1'b1;
        rq0_data  = 64'h55;
        rq0_last  = 1'b0;
        tick(3);
        rst = 1'b1;
        rq0_valid = 1'b0;
        @(negedge clk);
        check("midrst_rq0_ready", {63'd0, rq0_ready}, 0);
        check("midrst_dp_in_valid", {63'd0, dp_in_valid}, 0);
        check("midrst_rsp_valid", {63'd0, rsp_valid}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        saw_rsp = 1'b0;
        saw_err = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid) saw_rsp = 1'b1;
            if (err_sticky) saw_err = 1'b1;
        end
        check("post_reset_no_rsp", {63'd0, saw_rsp}, 0);
        check("post_reset_no_err", {63'd0, saw_err}, 0);

        // Full credit after reset: exactly FIFO_DEPTH beats go out with responses blocked.
        @(posedge clk); #1;
        base = n_issued;
        drv_done = 1'b0;
        for (int i = 0; i < 9; i++) push_exp(64'h200 + i, 1'b0, i == 8);
        fork
            begin
                for (int i = 0; i < 9; i++) send_beat(0, 64'h200 + i, i == 8);
                drv_done = 1'b1;
            end
        join_none
        tick(30);
        @(negedge clk);
        check("post_reset_credit", n_issued - base, FIFO_DEPTH);
        @(posedge clk); #1; rsp_ready = 1'b1;
        wait_done();
        wait_drain();
        check("post_reset_err_final", {63'd0, err_sticky}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
